// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage: NOP encoding, reset PC, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package fetch_unit_pkg;

  // addi x0, x0, 0 -- the bubble instruction placed in IF/ID
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Default first fetch address after reset
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // REQ: ready to issue; WAIT: one request outstanding; HOLD: response parked behind stallD
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Fetch PC register: redirect has priority over advance, otherwise holds.
// Latency: 1 cycle from redirect/advance to new pc.
// Backpressure: none; the caller only pulses advance when an instruction is consumed.
module fetch_unit_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] target,
  input  logic        advance,
  output logic [31:0] pc
);

  // PC update; +4 wraps modulo 2^32 naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= target;
    end else if (advance) begin
      pc <= pc + 32'd4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with one outstanding imem request, a one-entry skid buffer and the IF/ID register.
// Latency: request issued the cycle the FSM is in REQ; IF/ID loads on the edge the response arrives (if not stalled).
// Backpressure: imemReady stalls issue; stallD parks a response in the skid buffer; flushD squashes everything in flight.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic [31:0] pcTargetE,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic        imemRvalid,
  input  logic [31:0] imemRdata,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pcPlus4D,
  output logic        validD,
  output logic        fetchBusy
);

  fetch_state_t state, state_n;
  logic         drop, drop_n;
  logic [31:0]  pcF;
  logic [31:0]  skid_instr;
  logic         skid_load;
  logic         ifid_load;
  logic         ifid_from_skid;
  logic         pc_advance;
  logic         handshake;

  // pcF only moves when an instruction enters IF/ID or on a redirect
  fetch_unit_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .redirect (flushD),
    .target   (pcTargetE),
    .advance  (pc_advance),
    .pc       (pcF)
  );

  // Request is gated by rst so nothing is issued while reset is held
  assign imemReq   = (state == REQ) && !stallF && !rst;
  assign imemAddr  = pcF;
  assign fetchBusy = (state != REQ);
  assign handshake = imemReq && imemReady;

  // Next-state and datapath control; a response is consumed only when not squashed
  always_comb begin
    state_n        = state;
    drop_n         = drop;
    skid_load      = 1'b0;
    ifid_load      = 1'b0;
    ifid_from_skid = 1'b0;
    pc_advance     = 1'b0;
    case (state)
      REQ: begin
        // a flush in the acceptance cycle makes the just-issued request stale
        if (handshake) begin
          state_n = WAIT;
          drop_n  = flushD;
        end
      end
      WAIT: begin
        if (imemRvalid) begin
          state_n = REQ;
          drop_n  = 1'b0;
          if (!drop && !flushD) begin
            if (stallD) begin
              skid_load = 1'b1;
              state_n   = HOLD;
            end else begin
              ifid_load  = 1'b1;
              pc_advance = 1'b1;
            end
          end
        end else if (flushD) begin
          drop_n = 1'b1;
        end
      end
      HOLD: begin
        if (flushD) begin
          state_n = REQ;
        end else if (!stallD) begin
          ifid_load      = 1'b1;
          ifid_from_skid = 1'b1;
          pc_advance     = 1'b1;
          state_n        = REQ;
        end
      end
      default: begin
        state_n = REQ;
        drop_n  = 1'b0;
      end
    endcase
  end

  // FSM state and squash flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REQ;
      drop  <= 1'b0;
    end else begin
      state <= state_n;
      drop  <= drop_n;
    end
  end

  // Skid buffer captures a response that arrives while decode is stalled
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_instr <= imemRdata;
    end
  end

  // IF/ID register: flush beats load, load beats bubble, stall holds
  always_ff @(posedge clk) begin
    if (rst) begin
      instrD   <= NOP;
      pcD      <= 32'd0;
      pcPlus4D <= 32'd0;
      validD   <= 1'b0;
    end else if (flushD) begin
      instrD <= NOP;
      validD <= 1'b0;
    end else if (ifid_load) begin
      instrD   <= ifid_from_skid ? skid_instr : imemRdata;
      pcD      <= pcF;
      pcPlus4D <= pcF + 32'd4;
      validD   <= 1'b1;
    end else if (!stallD) begin
      instrD <= NOP;
      validD <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table, reset-mid-WAIT sequence, then random traffic vs a transaction model.
// Latency: n/a.
// Backpressure: bench plays imem with random ready and response latency.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stallF, stallD, flushD;
  logic [31:0] pcTargetE;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady, imemRvalid;
  logic [31:0] imemRdata;
  logic [31:0] instrD, pcD, pcPlus4D;
  logic        validD, fetchBusy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stallF     (stallF),
    .stallD     (stallD),
    .flushD     (flushD),
    .pcTargetE  (pcTargetE),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemReady  (imemReady),
    .imemRvalid (imemRvalid),
    .imemRdata  (imemRdata),
    .instrD     (instrD),
    .pcD        (pcD),
    .pcPlus4D   (pcPlus4D),
    .validD     (validD),
    .fetchBusy  (fetchBusy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Instruction memory contents used by the random phase
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
  endfunction

  // One directed cycle: inputs, pre-edge combinational expectations, post-edge IF/ID expectations
  typedef struct {
    logic        sf, sd, fl;
    logic [31:0] tgt;
    logic        rdy, rv;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        busy;
    logic        v;
    logic [31:0] pc, p4, instr;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic sf, input logic sd, input logic fl, input logic [31:0] tgt,
                         input logic rdy, input logic rv, input logic [31:0] rdata,
                         input logic req, input logic [31:0] addr, input logic busy,
                         input logic v, input logic [31:0] pc, input logic [31:0] p4,
                         input logic [31:0] instr);
    vec_t r;
    r.sf = sf; r.sd = sd; r.fl = fl; r.tgt = tgt; r.rdy = rdy; r.rv = rv; r.rdata = rdata;
    r.req = req; r.addr = addr; r.busy = busy; r.v = v; r.pc = pc; r.p4 = p4; r.instr = instr;
    vecs.push_back(r);
  endtask

  // Random-phase model: requests in flight, a response awaiting decode, and the program-order PC
  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          lat;
  } inflight_t;

  inflight_t   oq[$];
  bit          tok;
  logic [31:0] mpc;
  logic        ev;
  logic [31:0] epc, ep4, ei;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t r;
    logic exp_req;

    rst = 1'b1; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0; pcTargetE = 32'd0;
    imemReady = 1'b0; imemRvalid = 1'b0; imemRdata = 32'd0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("reset validD", validD, 0);
    chk("reset instrD", instrD, NOP);
    chk("reset pcD", pcD, 0);
    chk("reset pcPlus4D", pcPlus4D, 0);
    chk("reset imemReq", imemReq, 0);
    chk("reset fetchBusy", fetchBusy, 0);
    rst = 1'b0;

    // Directed table: streaming, decode stall into HOLD, flush in WAIT/HOLD, ready stall, wrap, protocol error
    add_vec(0,0,0,0,            1,0,0,            1,32'h0,0,        0,0,0,NOP);
    add_vec(0,0,0,0,            0,1,32'h1000_0000, 0,0,1,           1,0,4,32'h1000_0000);
    add_vec(0,0,0,0,            1,0,0,            1,32'h4,0,        0,0,0,NOP);
    add_vec(0,0,0,0,            0,1,32'h1000_0004, 0,0,1,           1,4,8,32'h1000_0004);
    add_vec(0,1,0,0,            1,0,0,            1,32'h8,0,        1,4,8,32'h1000_0004);
    add_vec(0,1,0,0,            0,1,32'h1000_0008, 0,0,1,           1,4,8,32'h1000_0004);
    add_vec(0,1,0,0,            0,0,0,            0,0,1,            1,4,8,32'h1000_0004);
    add_vec(0,1,0,0,            0,0,0,            0,0,1,            1,4,8,32'h1000_0004);
    add_vec(0,0,0,0,            0,0,0,            0,0,1,            1,8,32'hC,32'h1000_0008);
    add_vec(0,0,0,0,            1,0,0,            1,32'hC,0,        0,0,0,NOP);
    add_vec(0,0,0,0,            0,1,32'h1000_000C, 0,0,1,           1,32'hC,32'h10,32'h1000_000C);
    add_vec(0,0,0,0,            1,0,0,            1,32'h10,0,       0,0,0,NOP);
    add_vec(0,0,1,32'h100,      0,0,0,            0,0,1,            0,0,0,NOP);
    add_vec(0,0,0,0,            0,1,32'h1000_0010, 0,0,1,           0,0,0,NOP);
    add_vec(0,0,0,0,            1,0,0,            1,32'h100,0,      0,0,0,NOP);
    add_vec(0,1,0,0,            0,1,32'h1000_0100, 0,0,1,           0,0,0,NOP);
    add_vec(0,1,1,32'h100,      0,0,0,            0,0,1,            0,0,0,NOP);
    for (int k = 0; k < 5; k++)
      add_vec(0,0,0,0,          0,0,0,            1,32'h100,0,      0,0,0,NOP);
    add_vec(0,0,0,0,            1,0,0,            1,32'h100,0,      0,0,0,NOP);
    add_vec(0,0,0,0,            0,1,32'h1000_0100, 0,0,1,           1,32'h100,32'h104,32'h1000_0100);
    add_vec(0,0,1,32'hFFFF_FFFC,1,0,0,            1,32'h104,0,      0,0,0,NOP);
    add_vec(0,0,0,0,            0,1,32'h1000_0104, 0,0,1,           0,0,0,NOP);
    add_vec(0,0,0,0,            1,0,0,            1,32'hFFFF_FFFC,0,0,0,0,NOP);
    add_vec(0,0,0,0,            0,1,32'hCAFE_0001, 0,0,1,           1,32'hFFFF_FFFC,32'h0,32'hCAFE_0001);
    add_vec(0,0,0,0,            1,0,0,            1,32'h0,0,        0,0,0,NOP);
    add_vec(0,0,0,0,            0,1,32'h1000_0000, 0,0,1,           1,0,4,32'h1000_0000);
    add_vec(0,0,0,0,            0,1,32'hDEAD_BEEF, 1,32'h4,0,       0,0,0,NOP);
    add_vec(0,0,0,0,            0,0,0,            1,32'h4,0,        0,0,0,NOP);
    add_vec(1,0,0,0,            1,0,0,            0,0,0,            0,0,0,NOP);
    add_vec(0,0,0,0,            0,0,0,            1,32'h4,0,        0,0,0,NOP);

    for (int i = 0; i < vecs.size(); i++) begin
      r = vecs[i];
      @(negedge clk);
      stallF = r.sf; stallD = r.sd; flushD = r.fl; pcTargetE = r.tgt;
      imemReady = r.rdy; imemRvalid = r.rv; imemRdata = r.rdata;
      #1;
      chk($sformatf("row%0d imemReq", i), imemReq, r.req);
      if (r.req) chk($sformatf("row%0d imemAddr", i), imemAddr, r.addr);
      chk($sformatf("row%0d fetchBusy", i), fetchBusy, r.busy);
      @(posedge clk); #1;
      chk($sformatf("row%0d validD", i), validD, r.v);
      chk($sformatf("row%0d instrD", i), instrD, r.instr);
      if (r.v) begin
        chk($sformatf("row%0d pcD", i), pcD, r.pc);
        chk($sformatf("row%0d pcPlus4D", i), pcPlus4D, r.p4);
      end
    end

    // Reset while a request is outstanding; the late response must be ignored
    @(negedge clk);
    stallF = 0; stallD = 0; flushD = 0; imemReady = 1; imemRvalid = 0;
    @(posedge clk); #1;
    chk("midwait fetchBusy", fetchBusy, 1);
    @(negedge clk);
    rst = 1; imemReady = 0;
    #1;
    chk("midwait rst imemReq", imemReq, 0);
    @(posedge clk); #1;
    chk("midwait rst fetchBusy", fetchBusy, 0);
    chk("midwait rst validD", validD, 0);
    chk("midwait rst instrD", instrD, NOP);
    chk("midwait rst pcD", pcD, 0);
    @(negedge clk);
    rst = 0; imemRvalid = 1; imemRdata = 32'hBAD0_0BAD;
    #1;
    chk("late rsp imemReq", imemReq, 1);
    chk("late rsp imemAddr", imemAddr, 32'h0);
    @(posedge clk); #1;
    chk("late rsp validD", validD, 0);
    chk("late rsp instrD", instrD, NOP);
    chk("late rsp fetchBusy", fetchBusy, 0);
    @(negedge clk);
    imemRvalid = 0;
    #1;
    chk("late rsp pc kept", imemAddr, 32'h0);

    // Random phase
    @(negedge clk);
    rst = 1; imemRvalid = 0; imemReady = 0; flushD = 0; stallD = 0; stallF = 0;
    @(negedge clk); @(negedge clk);
    oq.delete(); tok = 0; mpc = 32'h0; ev = 0; epc = 0; ep4 = 0; ei = NOP;
    for (int c = 0; c < 3000; c++) begin
      chk("rand validD", validD, ev);
      chk("rand instrD", instrD, ei);
      if (ev) begin
        chk("rand pcD", pcD, epc);
        chk("rand pcPlus4D", pcPlus4D, ep4);
      end
      rst       = 0;
      stallF    = ($urandom_range(0, 5) == 0);
      stallD    = ($urandom_range(0, 3) == 0);
      flushD    = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0: pcTargetE = 32'h0000_0100;
        1: pcTargetE = 32'h0000_2000;
        2: pcTargetE = 32'hFFFF_FFF0;
        default: pcTargetE = {$urandom_range(0, 32'hFFFF), 16'h0} | {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      endcase
      imemReady = ($urandom_range(0, 2) != 0);
      if (oq.size() > 0 && oq[0].lat == 0 && $urandom_range(0, 2) != 0) begin
        imemRvalid = 1;
        imemRdata  = mem_word(oq[0].addr);
      end else begin
        imemRvalid = 0;
        imemRdata  = $urandom;
      end
      #1;
      exp_req = (oq.size() == 0) && !tok && !stallF;
      chk("rand imemReq", imemReq, exp_req);
      if (exp_req) chk("rand imemAddr", imemAddr, mpc);
      chk("rand fetchBusy", fetchBusy, (oq.size() != 0) || tok);

      // Model of the coming clock edge
      if (imemRvalid) begin
        if (!oq[0].stale) tok = 1;
        void'(oq.pop_front());
      end
      for (int k = 0; k < oq.size(); k++)
        if (oq[k].lat > 0) oq[k].lat = oq[k].lat - 1;
      if (exp_req && imemReady) begin
        inflight_t e;
        e.addr = mpc; e.stale = 0; e.lat = $urandom_range(0, 2);
        oq.push_back(e);
      end
      if (flushD) begin
        for (int k = 0; k < oq.size(); k++) oq[k].stale = 1;
        tok = 0;
        mpc = pcTargetE;
        ev  = 0;
        ei  = NOP;
      end else if (!stallD) begin
        if (tok) begin
          ev  = 1;
          epc = mpc;
          ep4 = mpc + 32'd4;
          ei  = mem_word(mpc);
          mpc = mpc + 32'd4;
          tok = 0;
        end else begin
          ev = 0;
          ei = NOP;
        end
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
